systolic_mac_array: RTL and testbench
=====================================

// Module: systolic_mac_array
// PURPOSE
//  Weight-stationary ARR_SIZE x ARR_SIZE signed MAC array; the compute stage directly
//  upstream of the accumulator. Holds one weight tile, accepts one activation vector
//  per cycle from the input-buffer path, and emits one ARR_SIZE-wide row of column
//  partial sums per vector, de-skewed and aligned, on the accumulator's input bus.
// PARAMETERS
//  ARR_SIZE  4   rows = columns of the PE grid
//  DATA_W    8   signed activation/weight width
//  ACC_W     32  per-column partial-sum width; mandatory ACC_W >= 2*DATA_W+clog2(ARR_SIZE)
// PORTS
//  clk            in   1                 single clock, rising edge
//  rst_n          in   1                 asynchronous active-low reset
//  wt_load_valid  in   1                 weight-row write request
//  wt_load_ready  out  1                 array can accept a weight-row write
//  wt_load_row    in   clog2(ARR_SIZE)   weight row index r
//  wt_load_data   in   ARR_SIZE*DATA_W   w[r][j]; column j at bits [j*DATA_W +: DATA_W]
//  act_valid      in   1                 activation vector present (always accepted)
//  act_data       in   ARR_SIZE*DATA_W   a[i]; row i at bits [i*DATA_W +: DATA_W]
//  psum_valid     out  1                 one-cycle pulse per completed vector
//  psum_out       out  ARR_SIZE*ACC_W    column sums; column j at bits [j*ACC_W +: ACC_W]
//  busy           out  1                 at least one vector in flight
// BEHAVIOUR
//  Reset (async assert, sync release): all weights, skew/deskew and PE registers,
//   psum_out, psum_valid and busy go to 0; wt_load_ready = 1.
//   In-flight vectors are discarded; no psum_valid after reset for pre-reset input.
//  Weight load: write occurs on the edge where wt_load_valid && wt_load_ready;
//   the whole row r is written in one cycle. wt_load_ready = !busy && !act_valid.
//   A request while not ready is ignored; weights stay unchanged and no error is raised.
//   Row indices >= ARR_SIZE are ignored (only when ARR_SIZE is not a power of 2).
//  Dataflow:
//   - Input skew: row i is delayed by i registers. Activations move left->right and
//     sums move top->bottom, 1 register per PE hop.
//   - PE(i,j): psum_o = psum_i + sext(a*w[i][j]). The product is signed DATA_W x DATA_W
//     to 2*DATA_W, sign-extended to ACC_W. The top-row psum_i is 0.
//   - Output deskew: column j is delayed by ARR_SIZE-1-j registers, so all columns
//     leave on the same edge.
//  Latency: a vector accepted at edge t gives psum_valid=1 and its psum_out in the
//   cycle after edge t+2*ARR_SIZE-1, i.e. exactly 2*ARR_SIZE cycles later (8 at
//   ARR_SIZE=4). Full throughput is 1 vector per cycle.
//  Ordering: results come out in input order. Idle cycles (act_valid=0) propagate as
//   bubbles with a valid tag and contribute nothing to any result.
//  Result: psum_out[j] = sum over i of a[i]*w[i][j], exact 2's complement with no
//   overflow under the ACC_W rule. psum_out is registered and updates only with
//   psum_valid; it holds the last result otherwise.
//  busy: set on the edge that accepts act_valid. It clears on the edge that presents
//   the last in-flight result (per-stage valid tags). While busy=1, wt_load_ready=0,
//   so weights never change under an in-flight vector.
//  Simultaneous wt_load_valid and act_valid: the activation is accepted and the load
//   is refused that cycle (ready=0).
// TESTING
//  1 Reset: drive rst_n=0 mid-cycle. Outputs are 0 immediately (async), wt_load_ready=1.
//  2 Identity weights (w[i][i]=1), act [1,2,3,4] -> psum_valid 8 cycles later with
//    psum_out [1,2,3,4], for exactly one cycle.
//  3 Signed extremes: all w=-128, all a=-128 -> every column = 65536. Also w=-1 with
//    a=[127,0,0,0] -> column 0 = -1*127 = -127 (0xFFFFFF81) and columns 1-3 = -127.
//  4 Stream 4 back-to-back vectors (1s,2s,3s,4s) with all-ones weights
//    -> 4 consecutive psum_valid cycles with columns 4, 8, 12, 16, in order.
//    Repeat with a one-cycle gap after vector 2 -> a one-cycle gap in psum_valid.
//  5 Assert wt_load_valid (row 0, new data) while busy -> wt_load_ready=0 and the next
//    results still use the old weights. Retry after busy falls -> load is taken.
//  6 Reset pulse 3 cycles after accepting a vector -> no psum_valid in the next
//    2*ARR_SIZE cycles, psum_out stays 0 and busy=0.

Source files
------------

// File: rtl/systolic_mac_array.sv
// Weight-stationary ARR_SIZE x ARR_SIZE signed MAC array with input skew, output
// deskew and a per-stage valid tag, feeding the accumulator one aligned row per vector.
module systolic_mac_array #(
  parameter int ARR_SIZE = 4,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 32,
  localparam int ROW_W   = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wt_load_valid,
  output logic                         wt_load_ready,
  input  logic [ROW_W-1:0]             wt_load_row,
  input  logic [ARR_SIZE*DATA_W-1:0]   wt_load_data,
  input  logic                         act_valid,
  input  logic [ARR_SIZE*DATA_W-1:0]   act_data,
  output logic                         psum_valid,
  output logic [ARR_SIZE*ACC_W-1:0]    psum_out,
  output logic                         busy
);

  localparam int PIPE = 2*ARR_SIZE - 1;

  logic signed [DATA_W-1:0] w_q   [ARR_SIZE][ARR_SIZE];
  logic signed [DATA_W-1:0] act_g [ARR_SIZE];
  logic signed [ACC_W-1:0]  col_out [ARR_SIZE];
  logic [PIPE-1:0]          vld_q;
  logic                     busy_q;
  logic                     psum_valid_q;
  logic [ARR_SIZE*ACC_W-1:0] psum_out_q;
  logic                     load_fire;

  assign wt_load_ready = !busy_q && !act_valid;
  assign load_fire     = wt_load_valid && wt_load_ready;
  assign busy          = busy_q;
  assign psum_valid    = psum_valid_q;
  assign psum_out      = psum_out_q;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    for (int i = 0; i < ARR_SIZE; i++) begin
      act_g[i] = '0;
      if (act_valid) act_g[i] = act_data[i*DATA_W +: DATA_W];
    end
  end

  // NOTE: the weight tile is reset so a vector issued straight after reset sees zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARR_SIZE; i++)
        for (int j = 0; j < ARR_SIZE; j++)
          w_q[i][j] <= '0;
    end else if (load_fire) begin
      for (int i = 0; i < ARR_SIZE; i++)
        if (wt_load_row == ROW_W'(i))
          for (int j = 0; j < ARR_SIZE; j++)
            w_q[i][j] <= wt_load_data[j*DATA_W +: DATA_W];
    end
  end

  for (genvar i = 0; i < ARR_SIZE; i++) begin : g_row
    logic signed [DATA_W-1:0] a_row;

    if (i == 0) begin : g_noskew
      assign a_row = act_g[0];
    end else begin : g_skew
      logic signed [DATA_W-1:0] sk_q [i];
      // NOTE: sequential state uses non-blocking assignments so the shift chain moves one hop per edge.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < i; k++) sk_q[k] <= '0;
        end else begin
          sk_q[0] <= act_g[i];
          for (int k = 1; k < i; k++) sk_q[k] <= sk_q[k-1];
        end
      end
      assign a_row = sk_q[i-1];
    end

    for (genvar j = 0; j < ARR_SIZE; j++) begin : g_pe
      logic signed [DATA_W-1:0]   a_in;
      logic signed [ACC_W-1:0]    ps_in;
      logic signed [ACC_W-1:0]    ps_q;
      logic signed [2*DATA_W-1:0] prod;

      if (j == 0) begin : g_ain0
        assign a_in = a_row;
      end else begin : g_ain
        assign a_in = g_row[i].g_pe[j-1].g_fwd.act_q;
      end

      if (i == 0) begin : g_top
        assign ps_in = '0;
      end else begin : g_psin
        assign ps_in = g_row[i-1].g_pe[j].ps_q;
      end

      if (j < ARR_SIZE-1) begin : g_fwd
        logic signed [DATA_W-1:0] act_q;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) act_q <= '0;
          else        act_q <= a_in;
        end
      end

      assign prod = a_in * w_q[i][j];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ps_q <= '0;
        else        ps_q <= ps_in + ACC_W'(prod);
      end
    end
  end

  // Columns further left finish earlier; delay them so the whole row leaves together.
  for (genvar j = 0; j < ARR_SIZE; j++) begin : g_col
    localparam int D = ARR_SIZE - 1 - j;
    if (D == 0) begin : g_nodly
      assign col_out[j] = g_row[ARR_SIZE-1].g_pe[j].ps_q;
    end else begin : g_dly
      logic signed [ACC_W-1:0] ds_q [D];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < D; k++) ds_q[k] <= '0;
        end else begin
          ds_q[0] <= g_row[ARR_SIZE-1].g_pe[j].ps_q;
          for (int k = 1; k < D; k++) ds_q[k] <= ds_q[k-1];
        end
      end
      assign col_out[j] = ds_q[D-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q        <= '0;
      busy_q       <= 1'b0;
      psum_valid_q <= 1'b0;
      psum_out_q   <= '0;
    end else begin
      vld_q        <= {vld_q[PIPE-2:0], act_valid};
      busy_q       <= act_valid || (|vld_q[PIPE-2:0]);
      psum_valid_q <= vld_q[PIPE-1];
      if (vld_q[PIPE-1])
        for (int j = 0; j < ARR_SIZE; j++)
          psum_out_q[j*ACC_W +: ACC_W] <= col_out[j];
    end
  end

endmodule

// File: tb/tb_systolic_mac_array.sv
// Directed bench for systolic_mac_array: stimulus pushes expected rows and due cycles
// into a scoreboard; a monitor pops and compares on every psum_valid.
module tb_systolic_mac_array;

  localparam int N = 4;
  localparam int DW = 8;
  localparam int AW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wt_load_valid;
  logic              wt_load_ready;
  logic [1:0]        wt_load_row;
  logic [N*DW-1:0]   wt_load_data;
  logic              act_valid;
  logic [N*DW-1:0]   act_data;
  logic              psum_valid;
  logic [N*AW-1:0]   psum_out;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [N*AW-1:0] exp_q[$];
  int              due_q[$];

  systolic_mac_array #(.ARR_SIZE(N), .DATA_W(DW), .ACC_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wt_load_valid(wt_load_valid), .wt_load_ready(wt_load_ready),
    .wt_load_row(wt_load_row), .wt_load_data(wt_load_data),
    .act_valid(act_valid), .act_data(act_data),
    .psum_valid(psum_valid), .psum_out(psum_out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [N*AW-1:0] act, input logic [N*AW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N*DW-1:0] p8(input int a0, input int a1, input int a2, input int a3);
    return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic logic [N*AW-1:0] p32(input int c0, input int c1, input int c2, input int c3);
    return {32'(c3), 32'(c2), 32'(c1), 32'(c0)};
  endfunction

  // Monitor: every psum_valid cycle must match the oldest expectation and its due cycle.
  always @(negedge clk) begin
    if (rst_n && psum_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected psum_valid", 1, 0);
      end else begin
        logic [N*AW-1:0] e;
        int d;
        e = exp_q.pop_front();
        d = due_q.pop_front();
        check("psum_out", psum_out, e);
        check("latency", cyc, d);
      end
    end
  end

  task automatic load_row(input logic [1:0] r, input logic [N*DW-1:0] d);
    @(negedge clk);
    wt_load_valid = 1'b1;
    wt_load_row   = r;
    wt_load_data  = d;
    #1 check("ready during load", wt_load_ready, 1);
    @(negedge clk);
    wt_load_valid = 1'b0;
  endtask

  task automatic load_all(input logic [N*DW-1:0] d);
    for (int r = 0; r < N; r++) load_row(2'(r), d);
  endtask

  task automatic send(input logic [N*DW-1:0] a, input logic [N*AW-1:0] e, input bit push);
    @(negedge clk);
    act_valid = 1'b1;
    act_data  = a;
    if (push) begin
      exp_q.push_back(e);
      due_q.push_back(cyc + 2*N);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      act_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("drain within budget", (k < 100), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    wt_load_valid = 1'b0;
    wt_load_row = '0;
    wt_load_data = '0;
    act_valid = 1'b0;
    act_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset psum_valid", psum_valid, 0);
    check("reset psum_out", psum_out, 0);
    check("reset busy", busy, 0);
    check("reset wt_load_ready", wt_load_ready, 1);
    rst_n = 1'b1;

    // Zero weights after reset give a zero row
    send(p8(5, 5, 5, 5), p32(0, 0, 0, 0), 1);
    #1 check("busy-free ready drops with act_valid", wt_load_ready, 0);
    @(negedge clk);
    act_valid = 1'b0;
    #1 check("busy after accept", busy, 1);
    drain();

    // Identity weights
    for (int r = 0; r < N; r++) load_row(2'(r), (N*DW)'(1) << (r*DW));
    send(p8(1, 2, 3, 4), p32(1, 2, 3, 4), 1);
    idle(1);
    drain();
    check("busy cleared", busy, 0);
    repeat (3) @(negedge clk);
    check("psum_out holds last", psum_out, p32(1, 2, 3, 4));

    // Mixed signs: row i = [i+1, -(i+1), 5, 0]
    for (int r = 0; r < N; r++) load_row(2'(r), p8(r+1, -(r+1), 5, 0));
    send(p8(3, -5, 7, -2), p32(6, -6, 15, 0), 1);
    idle(1);
    drain();

    // Signed extremes
    load_all(p8(-128, -128, -128, -128));
    send(p8(-128, -128, -128, -128), p32(65536, 65536, 65536, 65536), 1);
    idle(1);
    drain();
    load_all(p8(-1, -1, -1, -1));
    send(p8(127, 0, 0, 0), p32(-127, -127, -127, -127), 1);
    idle(1);
    drain();

    // Back-to-back stream, then the same with a one-cycle gap after vector 2
    load_all(p8(1, 1, 1, 1));
    for (int v = 1; v <= 4; v++) send(p8(v, v, v, v), p32(4*v, 4*v, 4*v, 4*v), 1);
    idle(1);
    drain();
    for (int v = 1; v <= 4; v++) begin
      send(p8(v, v, v, v), p32(4*v, 4*v, 4*v, 4*v), 1);
      if (v == 2) idle(1);
    end
    idle(1);
    drain();

    // Weight load refused while a vector is in flight
    @(negedge clk);
    act_valid = 1'b1;
    act_data = p8(1, 1, 1, 1);
    exp_q.push_back(p32(4, 4, 4, 4));
    due_q.push_back(cyc + 2*N);
    wt_load_valid = 1'b1;
    wt_load_row = 2'd0;
    wt_load_data = p8(2, 2, 2, 2);
    #1 check("ready with act_valid and load", wt_load_ready, 0);
    @(negedge clk);
    act_valid = 1'b0;
    #1 check("ready while busy", wt_load_ready, 0);
    send(p8(1, 1, 1, 1), p32(4, 4, 4, 4), 1);
    @(negedge clk);
    act_valid = 1'b0;
    wt_load_valid = 1'b0;
    drain();
    load_row(2'd0, p8(2, 2, 2, 2));
    send(p8(1, 1, 1, 1), p32(5, 5, 5, 5), 1);
    idle(1);
    drain();

    // Reset three cycles after accepting a vector discards it
    send(p8(7, 7, 7, 7), '0, 0);
    @(negedge clk);
    act_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset busy", busy, 0);
    check("async reset psum_out", psum_out, 0);
    check("async reset psum_valid", psum_valid, 0);
    check("async reset ready", wt_load_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2*N + 2; k++) begin
      @(negedge clk);
      check("post-reset psum_valid", psum_valid, 0);
      check("post-reset psum_out", psum_out, 0);
      check("post-reset busy", busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
